// File: rtl/mult_add_acc_pipe_pkg.sv
// Shared widths, saturation limits and side-tag layout for the multiply-add pipeline.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package mult_add_acc_pipe_pkg;

  // Wide enough to hold any accumulator limit this block can be configured for.
  localparam int LIMIT_W = 128;
  localparam logic signed [LIMIT_W-1:0] LIMIT_ONE = 1;

  // Side tags that travel with each sample through every stage.
  typedef struct packed {
    logic acc_en;
    logic acc_load;
  } tag_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  function automatic int prod_w(input int dw, input int cw);
    return dw + cw;
  endfunction

  function automatic int sum_w(input int dw, input int cw, input int n_ch);
    return dw + cw + clog2(n_ch);
  endfunction

  function automatic logic signed [LIMIT_W-1:0] sat_max(input int acc_w);
    return (LIMIT_ONE <<< (acc_w - 1)) - LIMIT_ONE;
  endfunction

  function automatic logic signed [LIMIT_W-1:0] sat_min(input int acc_w);
    return -(LIMIT_ONE <<< (acc_w - 1));
  endfunction

endpackage

// File: rtl/mult_add_acc_pipe_adder_tree.sv
// Registered pairwise reduction of N_OP signed operands, carrying a valid bit and side tag.
// Latency: clog2(N_OP) cycles, one register level per tree level.
// Backpressure: none; clken low freezes every level, tags and valid included.
//
// Ports: in_vld/in_tag/in_dat (N_OP packed operands, op k at [k*IN_W +: IN_W]),
//        out_vld/out_tag/out_dat (signed sum, IN_W+clog2(N_OP) bits).
module adder_tree_pipe
  import mult_add_acc_pipe_pkg::*;
#(
  parameter int N_OP  = 4,
  parameter int IN_W  = 36,
  parameter int TAG_W = 2,
  localparam int LVLS  = clog2(N_OP),
  localparam int OUT_W = IN_W + LVLS
) (
  input  logic                    clk,
  input  logic                    aclr_n,
  input  logic                    clken,
  input  logic                    in_vld,
  input  logic [TAG_W-1:0]        in_tag,
  input  logic [N_OP*IN_W-1:0]    in_dat,
  output logic                    out_vld,
  output logic [TAG_W-1:0]        out_tag,
  output logic signed [OUT_W-1:0] out_dat
);

  // Number of live operands at a given level (ceil(N_OP / 2^lvl)).
  function automatic int cnt_at(input int lvl);
    return (N_OP + (1 << lvl) - 1) >> lvl;
  endfunction

  for (genvar l = 0; l <= LVLS; l++) begin : g_lvl
    localparam int W   = IN_W + l;
    localparam int CNT = cnt_at(l);

    logic signed [W-1:0] dat [CNT];
    logic                vld;
    logic [TAG_W-1:0]    tag;

    if (l == 0) begin : g_in
      for (genvar i = 0; i < CNT; i++) begin : g_op
        assign dat[i] = in_dat[i*IN_W +: IN_W];
      end
      assign vld = in_vld;
      assign tag = in_tag;
    end else begin : g_reg
      localparam int PCNT = cnt_at(l - 1);

      always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
          vld <= 1'b0;
          tag <= '0;
        end else if (clken) begin
          vld <= g_lvl[l-1].vld;
          tag <= g_lvl[l-1].tag;
        end
      end

      for (genvar i = 0; i < CNT; i++) begin : g_node
        if (2*i + 1 < PCNT) begin : g_add
          always_ff @(posedge clk or negedge aclr_n) begin
            if (!aclr_n) dat[i] <= '0;
            else if (clken)
              dat[i] <= {g_lvl[l-1].dat[2*i][W-2], g_lvl[l-1].dat[2*i]} +
                        {g_lvl[l-1].dat[2*i+1][W-2], g_lvl[l-1].dat[2*i+1]};
          end
        end else begin : g_pass
          // Odd operand out: carry it up one level, sign-extended.
          always_ff @(posedge clk or negedge aclr_n) begin
            if (!aclr_n) dat[i] <= '0;
            else if (clken) dat[i] <= {g_lvl[l-1].dat[2*i][W-2], g_lvl[l-1].dat[2*i]};
          end
        end
      end
    end
  end

  assign out_dat = g_lvl[LVLS].dat[0];
  assign out_vld = g_lvl[LVLS].vld;
  assign out_tag = g_lvl[LVLS].tag;

endmodule

// File: rtl/mult_add_acc_pipe.sv
// N-channel signed multiply-add with runtime coefficient file and saturating accumulator.
// Latency: 3 + clog2(N_CH) cycles from accepted in_valid to out_valid (5 for N_CH=4).
// Backpressure: none; clken low freezes all stages and outputs (out_valid holds).
//
// Ports: din (packed samples, ch k at [k*DW +: DW]) with in_valid/acc_en/acc_load;
//        coef_wr/coef_idx/coef_data load the coefficient file (ignores clken);
//        out_valid/result/ovf carry the sum or accumulator and the sticky overflow flag.
module mult_add_acc_pipe
  import mult_add_acc_pipe_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int DW    = 18,
  parameter int CW    = 18,
  parameter int ACC_W = 44,
  localparam int IDX_W = clog2(N_CH)
) (
  input  logic                    clk,
  input  logic                    aclr_n,
  input  logic                    clken,
  input  logic                    in_valid,
  input  logic [N_CH*DW-1:0]      din,
  input  logic                    acc_en,
  input  logic                    acc_load,
  input  logic                    coef_wr,
  input  logic [IDX_W-1:0]        coef_idx,
  input  logic signed [CW-1:0]    coef_data,
  output logic                    out_valid,
  output logic signed [ACC_W-1:0] result,
  output logic                    ovf
);

  localparam int PROD_W = prod_w(DW, CW);
  localparam int SUM_W  = sum_w(DW, CW, N_CH);
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(sat_max(ACC_W));
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(sat_min(ACC_W));

  // Coefficient file
  logic signed [CW-1:0] coef_q [N_CH];

  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      for (int k = 0; k < N_CH; k++) coef_q[k] <= '0;
    end else if (coef_wr && ({1'b0, coef_idx} < (IDX_W+1)'(N_CH))) begin
      coef_q[coef_idx] <= coef_data;
    end
  end

  // S0: sample, tags and a coefficient snapshot, so later writes cannot
  // disturb a sample already in flight.
  logic signed [DW-1:0] s0_din  [N_CH];
  logic signed [CW-1:0] s0_coef [N_CH];
  logic                 s0_vld;
  tag_t                 s0_tag;

  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      s0_vld <= 1'b0;
      s0_tag <= '0;
      for (int k = 0; k < N_CH; k++) begin
        s0_din[k]  <= '0;
        s0_coef[k] <= '0;
      end
    end else if (clken) begin
      s0_vld <= in_valid;
      s0_tag <= '{acc_en: acc_en, acc_load: acc_load};
      for (int k = 0; k < N_CH; k++) begin
        s0_din[k]  <= din[k*DW +: DW];
        s0_coef[k] <= coef_q[k];
      end
    end
  end

  // S1: full-precision signed products
  logic signed [PROD_W-1:0] s1_prod [N_CH];
  logic                     s1_vld;
  tag_t                     s1_tag;
  logic [N_CH*PROD_W-1:0]   s1_flat;

  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      s1_vld <= 1'b0;
      s1_tag <= '0;
      for (int k = 0; k < N_CH; k++) s1_prod[k] <= '0;
    end else if (clken) begin
      s1_vld <= s0_vld;
      s1_tag <= s0_tag;
      for (int k = 0; k < N_CH; k++)
        s1_prod[k] <= PROD_W'(s0_din[k]) * PROD_W'(s0_coef[k]);
    end
  end

  for (genvar k = 0; k < N_CH; k++) begin : g_flat
    assign s1_flat[k*PROD_W +: PROD_W] = s1_prod[k];
  end

  // Adder tree
  logic                    t_vld;
  tag_t                    t_tag;
  logic signed [SUM_W-1:0] t_sum;

  adder_tree_pipe #(
    .N_OP  (N_CH),
    .IN_W  (PROD_W),
    .TAG_W ($bits(tag_t))
  ) u_tree (
    .clk     (clk),
    .aclr_n  (aclr_n),
    .clken   (clken),
    .in_vld  (s1_vld),
    .in_tag  (s1_tag),
    .in_dat  (s1_flat),
    .out_vld (t_vld),
    .out_tag (t_tag),
    .out_dat (t_sum)
  );

  // Output / accumulator stage. One extra bit on the add exposes overflow as
  // a disagreement between the two top bits.
  logic signed [ACC_W-1:0] sum_ext;
  logic signed [ACC_W:0]   acc_nxt;
  logic                    pos_ovf;
  logic                    neg_ovf;

  assign sum_ext = ACC_W'(t_sum);
  assign acc_nxt = (ACC_W+1)'(result) + (ACC_W+1)'(sum_ext);
  assign pos_ovf = !acc_nxt[ACC_W] &&  acc_nxt[ACC_W-1];
  assign neg_ovf =  acc_nxt[ACC_W] && !acc_nxt[ACC_W-1];

  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      out_valid <= 1'b0;
      result    <= '0;
      ovf       <= 1'b0;
    end else if (clken) begin
      out_valid <= t_vld;
      if (t_vld) begin
        if (t_tag.acc_en && !t_tag.acc_load) begin
          if (pos_ovf) begin
            result <= SAT_MAX;
            ovf    <= 1'b1;
          end else if (neg_ovf) begin
            result <= SAT_MIN;
            ovf    <= 1'b1;
          end else begin
            result <= acc_nxt[ACC_W-1:0];
          end
        end else begin
          result <= sum_ext;
          ovf    <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_mult_add_acc_pipe.sv
// Bench for mult_add_acc_pipe: directed scenarios plus randomized traffic against a reference model.
// Latency: n/a.
// Backpressure: clken is exercised as a stall source.
module tb_mult_add_acc_pipe;

  localparam int N  = 4;
  localparam int DW = 18;
  localparam int CW = 18;
  localparam int AW = 38;
  localparam int L  = 5;  // register stages from input to result for N=4
  localparam longint ACC_MAX = (64'sd1 <<< (AW - 1)) - 64'sd1;
  localparam longint ACC_MIN = -(64'sd1 <<< (AW - 1));

  logic                 clk = 1'b0;
  logic                 aclr_n;
  logic                 clken;
  logic                 in_valid;
  logic [N*DW-1:0]      din;
  logic                 acc_en;
  logic                 acc_load;
  logic                 coef_wr;
  logic [1:0]           coef_idx;
  logic signed [CW-1:0] coef_data;
  logic                 out_valid;
  logic signed [AW-1:0] result;
  logic                 ovf;

  always #5 clk = ~clk;

  mult_add_acc_pipe #(.N_CH(N), .DW(DW), .CW(CW), .ACC_W(AW)) dut (
    .clk       (clk),
    .aclr_n    (aclr_n),
    .clken     (clken),
    .in_valid  (in_valid),
    .din       (din),
    .acc_en    (acc_en),
    .acc_load  (acc_load),
    .coef_wr   (coef_wr),
    .coef_idx  (coef_idx),
    .coef_data (coef_data),
    .out_valid (out_valid),
    .result    (result),
    .ovf       (ovf)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Reference model: per accepted sample, the dot product and accumulator rule
  // are evaluated in plain integer arithmetic and queued with the enabled-edge
  // count at which the result must appear.
  typedef struct {
    longint res;
    bit     ovf;
    longint due;
  } exp_t;

  exp_t   exp_q[$];
  longint m_coef [N];
  longint sh_acc  = 0;
  bit     sh_ovf  = 0;
  longint en_cnt  = 0;
  bit     m_vld   = 0;
  longint m_res   = 0;
  bit     m_ovf   = 0;
  longint m_sum;
  longint m_tmp;

  always @(posedge clk) begin
    if (!aclr_n) begin
      exp_q.delete();
      for (int k = 0; k < N; k++) m_coef[k] = 0;
      sh_acc = 0; sh_ovf = 0; en_cnt = 0;
      m_vld = 0; m_res = 0; m_ovf = 0;
    end else begin
      if (clken) begin
        en_cnt++;
        m_vld = 0;
        if (exp_q.size() > 0 && exp_q[0].due == en_cnt) begin
          m_vld = 1;
          m_res = exp_q[0].res;
          m_ovf = exp_q[0].ovf;
          void'(exp_q.pop_front());
        end
        if (in_valid) begin
          m_sum = 0;
          for (int k = 0; k < N; k++)
            m_sum += longint'($signed(din[k*DW +: DW])) * m_coef[k];
          if (acc_en && !acc_load) begin
            m_tmp = sh_acc + m_sum;
            if (m_tmp > ACC_MAX)      begin sh_acc = ACC_MAX; sh_ovf = 1; end
            else if (m_tmp < ACC_MIN) begin sh_acc = ACC_MIN; sh_ovf = 1; end
            else                            sh_acc = m_tmp;
          end else begin
            sh_acc = m_sum;
            sh_ovf = 0;
          end
          exp_q.push_back('{sh_acc, sh_ovf, en_cnt + L - 1});
        end
      end
      // Coefficient write lands after this edge's snapshot.
      if (coef_wr) m_coef[coef_idx] = longint'(coef_data);
    end
  end

  always @(posedge clk) begin
    #1;
    check("model_vld", out_valid, m_vld);
    check("model_result", result, m_res);
    check("model_ovf", ovf, m_ovf);
  end

  function automatic logic [N*DW-1:0] pack4(input int a, input int b, input int c, input int d);
    return {DW'(d), DW'(c), DW'(b), DW'(a)};
  endfunction

  // All driving tasks start and end on a falling edge.
  task automatic wr_coef(input int idx, input int val);
    coef_wr = 1'b1; coef_idx = 2'(idx); coef_data = CW'(val);
    @(negedge clk);
    coef_wr = 1'b0;
  endtask

  task automatic wr_all(input int val);
    for (int k = 0; k < N; k++) wr_coef(k, val);
  endtask

  task automatic wait_out(input string tag, input longint exp_res, input logic exp_ovf);
    int n = 0;
    while (n < 20) begin
      @(posedge clk); #1;
      if (out_valid) break;
      n++;
    end
    check({tag, "_seen"}, out_valid, 1);
    check(tag, result, exp_res);
    check({tag, "_ovf"}, ovf, exp_ovf);
    @(negedge clk);
  endtask

  task automatic run(input string tag, input int a, input int b, input int c, input int d,
                     input logic ae, input logic al, input longint exp_res, input logic exp_ovf);
    din = pack4(a, b, c, d); acc_en = ae; acc_load = al; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    wait_out(tag, exp_res, exp_ovf);
  endtask

  initial begin
    aclr_n = 1'b0; clken = 1'b1; in_valid = 1'b0; din = '0;
    acc_en = 1'b0; acc_load = 1'b0; coef_wr = 1'b0; coef_idx = '0; coef_data = '0;
    repeat (3) @(negedge clk);
    check("rst_vld", out_valid, 0);
    check("rst_result", result, 0);
    check("rst_ovf", ovf, 0);
    aclr_n = 1'b1;

    // Coefficient load and exact latency
    for (int k = 0; k < N; k++) wr_coef(k, k + 1);
    din = pack4(10, 20, 30, 40); in_valid = 1'b1;
    for (int c = 1; c <= L; c++) begin
      @(posedge clk); #1;
      check("lat_vld", out_valid, c == L);
      if (c < L) begin
        check("lat_pre_result", result, 0);
        check("lat_pre_ovf", ovf, 0);
      end
      @(negedge clk);
      in_valid = 1'b0;
    end
    check("sum300", result, 300);

    // Signed extremes
    wr_all(-131072);
    run("extreme", -131072, -131072, -131072, -131072, 1'b0, 1'b0, 64'sd68719476736, 1'b0);

    // Accumulate / reload
    wr_all(1);
    run("acc_load", 1, 1, 1, 1, 1'b1, 1'b1, 4, 1'b0);
    run("acc_1", 1, 1, 1, 1, 1'b1, 1'b0, 8, 1'b0);
    run("acc_2", 1, 1, 1, 1, 1'b1, 1'b0, 12, 1'b0);
    run("acc_3", 1, 1, 1, 1, 1'b1, 1'b0, 16, 1'b0);
    run("reload", 1, 1, 1, 1, 1'b1, 1'b1, 4, 1'b0);

    // Positive and negative saturation, sticky ovf
    wr_all(-131072);
    run("sat_load", -131072, -131072, -131072, -131072, 1'b1, 1'b1, 64'sd68719476736, 1'b0);
    run("sat_pos", -131072, -131072, -131072, -131072, 1'b1, 1'b0, ACC_MAX, 1'b1);
    run("sat_hold", -131072, -131072, -131072, -131072, 1'b1, 1'b0, ACC_MAX, 1'b1);
    run("sat_clear", -131072, -131072, -131072, -131072, 1'b1, 1'b1, 64'sd68719476736, 1'b0);
    wr_all(131071);
    run("neg_load", -131072, -131072, -131072, -131072, 1'b1, 1'b1, -64'sd68718952448, 1'b0);
    run("neg_acc", -131072, -131072, -131072, -131072, 1'b1, 1'b0, -64'sd137437904896, 1'b0);
    run("sat_neg", -131072, -131072, -131072, -131072, 1'b1, 1'b0, ACC_MIN, 1'b1);

    // clken stall mid-flight; a sample offered during the stall must be ignored
    for (int k = 0; k < N; k++) wr_coef(k, int'($urandom_range(0, 2000)) - 1000);
    for (int c = 0; c < 10; c++) begin
      in_valid = (c < 3) || (c == 5);
      for (int k = 0; k < N; k++) din[k*DW +: DW] = DW'($urandom);
      acc_en = 1'b0; acc_load = 1'b0;
      clken = !(c >= 4 && c < 8);
      @(negedge clk);
    end
    clken = 1'b1; in_valid = 1'b0;
    repeat (8) @(negedge clk);

    // Coefficient write on the capture edge
    wr_all(1);
    din = pack4(7, 1, 1, 1); in_valid = 1'b1; acc_en = 1'b0;
    coef_wr = 1'b1; coef_idx = 2'd0; coef_data = 18'sd5;
    @(negedge clk);
    coef_wr = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    wait_out("coef_old", 10, 1'b0);
    wait_out("coef_new", 38, 1'b0);

    // Reset mid-flight discards everything in the pipe
    din = pack4(3, 3, 3, 3); in_valid = 1'b1;
    repeat (2) @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    aclr_n = 1'b0;
    repeat (2) @(negedge clk);
    aclr_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      check("rst_flush", out_valid, 0);
    end
    @(negedge clk);

    // Randomized traffic
    for (int c = 0; c < 400; c++) begin
      clken    = ($urandom_range(0, 7) != 0);
      in_valid = ($urandom_range(0, 2) != 0);
      for (int k = 0; k < N; k++)
        din[k*DW +: DW] = (c % 3 == 0) ? DW'(int'($urandom_range(0, 40)) - 20) : DW'($urandom);
      acc_en    = 1'($urandom);
      acc_load  = ($urandom_range(0, 3) == 0);
      coef_wr   = ($urandom_range(0, 3) == 0);
      coef_idx  = 2'($urandom);
      coef_data = CW'($urandom);
      if (c == 200) aclr_n = 1'b0;
      if (c == 203) aclr_n = 1'b1;
      @(negedge clk);
    end
    clken = 1'b1; in_valid = 1'b0; coef_wr = 1'b0;
    repeat (10) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
